// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment scan decoder: active-low segment patterns,
// the captured bus sample type, scan FSM states and anode helper functions.
package sevenseg_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns, identical to the display driver's encoder.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef struct packed {
        logic [7:0] anode;
        logic [6:0] cathode;
    } bus_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } scan_state_e;

    function automatic logic [3:0] low_count(input logic [7:0] a);
        low_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            low_count = low_count + {3'd0, ~a[i]};
        end
    endfunction

    // Index of the lowest driven (low) anode; only meaningful when exactly one is low.
    function automatic logic [2:0] low_index(input logic [7:0] a);
        low_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!a[i]) low_index = 3'(i);
        end
    endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_pattern.sv
// seg7_pattern_decode: combinational inverse of the driver's segment encoder.
// hit is low for any cathode pattern that is not one of the sixteen hex glyphs.
module seg7_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] cathode,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves one unassigned (no latch).
        hit    = 1'b1;
        nibble = 4'h0;
        case (cathode)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Rebuilds the hex value shown on a multiplexed 7-segment bus for loopback checking.
// Optional SCAN_ERR_CNT_EN adds err_count, a saturating count of decode and multi-anode errors.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [6:0]          cathode,
    input  logic [7:0]          anode,
    output logic [4*DIGITS-1:0] number,
    output logic                frame_valid,
    output logic                frame_err,
    output logic                decode_err
`ifdef SCAN_ERR_CNT_EN
    ,
    output logic [7:0]          err_count
`endif
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // A single identical sample is already enough when SETTLE_CYCLES is 1.
    localparam scan_state_e ENTRY = (SETTLE_CYCLES == 1) ? ST_CAPTURE : ST_SETTLE;

    bus_sample_t          sample_q, prev_q, ref_q;
    scan_state_e          state_q, state_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic [DIGITS-1:0]    seen_q;
    logic [4*DIGITS-1:0]  shadow_q;
    logic                 bad_q, dec_pend_q;
    logic                 active, capture, frame_done, hit;
    logic [2:0]           low_idx;
    logic [IW-1:0]        cap_idx;
    logic [3:0]           nibble;

    assign low_idx    = low_index(sample_q.anode);
    assign active     = (low_count(sample_q.anode) == 4'd1) && (32'(low_idx) < DIGITS);
    assign capture    = (state_q == ST_CAPTURE);
    // In CAPTURE, prev_q is the last sample that passed the settle check.
    assign cap_idx    = IW'(low_index(prev_q.anode));
    assign frame_done = &seen_q;

    seg7_pattern_decode u_decode (
        .cathode (prev_q.cathode),
        .hit     (hit),
        .nibble  (nibble)
    );

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    state_n = ENTRY;
                    cnt_n   = CW'(1);
                end
            end
            ST_SETTLE: begin
                if (sample_q == prev_q) begin
                    if (32'(cnt_q) + 1 >= SETTLE_CYCLES) state_n = ST_CAPTURE;
                    else                                  cnt_n   = cnt_q + 1'b1;
                end else if (active) begin
                    state_n = ENTRY;
                    cnt_n   = CW'(1);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CAPTURE: state_n = ST_HOLD;
            ST_HOLD: begin
                // Compared against the captured digit so a change during CAPTURE is not missed.
                if (sample_q != ref_q) begin
                    state_n = active ? ENTRY : ST_IDLE;
                    cnt_n   = CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            sample_q    <= '1;
            prev_q      <= '1;
            ref_q       <= '1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            seen_q      <= '0;
            bad_q       <= 1'b0;
            dec_pend_q  <= 1'b0;
            number      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            sample_q    <= {anode, cathode};
            prev_q      <= sample_q;
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            frame_valid <= frame_done && !bad_q;
            frame_err   <= frame_done && bad_q;
            // Delayed one extra cycle so it lines up with the frame verdict of the same capture.
            dec_pend_q  <= capture && !hit;
            decode_err  <= dec_pend_q;
            if (frame_done) begin
                seen_q <= '0;
                bad_q  <= 1'b0;
                if (!bad_q) number <= shadow_q;
            end
            if (capture) begin
                ref_q           <= prev_q;
                seen_q[cap_idx] <= 1'b1;
                if (!hit) bad_q <= 1'b1;
            end
        end
    end

    // NOTE: shadow is not reset; it only reaches number after every digit has been rewritten.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && (cap_idx == IW'(i))) shadow_q[4*i +: 4] <= hit ? nibble : 4'h0;
        end
    end

`ifdef SCAN_ERR_CNT_EN
    logic       multi_low, multi_q;
    logic [1:0] err_inc;

    assign multi_low = (low_count(sample_q.anode) >= 4'd2);
    assign err_inc   = {1'b0, decode_err} + {1'b0, multi_low && !multi_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            multi_q   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            multi_q <= multi_low;
            if ({1'b0, err_count} + {7'd0, err_inc} > 9'd255) err_count <= 8'hFF;
            else                                             err_count <= err_count + {6'd0, err_inc};
        end
    end
`endif

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder (DIGITS=4, SETTLE_CYCLES=2); err_count checks
// are compiled in when SCAN_ERR_CNT_EN is defined.
module tb_sevenseg_scan_decoder;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  cathode = 7'h7F;
    logic [7:0]  anode = 8'hFF;
    logic [15:0] number;
    logic        frame_valid, frame_err, decode_err;
`ifdef SCAN_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    int fv_total = 0, fe_total = 0, de_total = 0, coinc_total = 0, both_total = 0;
    logic [15:0] frames_q[$];

    sevenseg_scan_decoder #(.DIGITS(4), .SETTLE_CYCLES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .cathode     (cathode),
        .anode       (anode),
        .number      (number),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .decode_err  (decode_err)
`ifdef SCAN_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_valid) begin
            fv_total++;
            frames_q.push_back(number);
        end
        if (frame_err)                 fe_total++;
        if (decode_err)                de_total++;
        if (decode_err && frame_err)   coinc_total++;
        if (frame_valid && frame_err)  both_total++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [7:0] an, input logic [6:0] ca, input int cycles);
        anode   = an;
        cathode = ca;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic present(input int d, input logic [3:0] nib, input int hold, input logic bad);
        drive(8'hFF ^ (8'h01 << d), bad ? 7'h7F : SEG_TAB[nib], hold);
    endtask

    task automatic scan(input logic [15:0] v, input int hold, input int bad_digit);
        for (int d = 0; d < 4; d++) present(d, v[4*d +: 4], hold, d == bad_digit);
    endtask

    task automatic idle(input int cycles);
        drive(8'hFF, 7'h7F, cycles);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (number !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_number: got %h, want 0000", number);
        end
        vectors++;
        if ({frame_valid, frame_err, decode_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b, want 000", {frame_valid, frame_err, decode_err});
        end
`ifdef SCAN_ERR_CNT_EN
        vectors++;
        if (err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_err_count: got %0d, want 0", err_count);
        end
`endif
    endtask

    task automatic test_short_hold();
        int fv0, de0;
        fv0 = fv_total; de0 = de_total;
        scan(16'h1234, 1, -1);
        idle(8);
        vectors++;
        if (fv_total - fv0 !== 0) begin
            miscompares++;
            $display("FAIL short_hold_frames: got %0d, want 0", fv_total - fv0);
        end
        vectors++;
        if (number !== 16'h0000 || de_total - de0 !== 0) begin
            miscompares++;
            $display("FAIL short_hold_number: got %h/%0d decode errs, want 0000/0", number, de_total - de0);
        end
    endtask

    task automatic test_scan_1234();
        int fv0, fe0;
        fv0 = fv_total; fe0 = fe_total;
        scan(16'h1234, 4, -1);
        idle(8);
        vectors++;
        if (fv_total - fv0 !== 1 || fe_total - fe0 !== 0) begin
            miscompares++;
            $display("FAIL scan1234_pulses: got fv=%0d fe=%0d, want fv=1 fe=0", fv_total - fv0, fe_total - fe0);
        end
        vectors++;
        if (number !== 16'h1234) begin
            miscompares++;
            $display("FAIL scan1234_number: got %h, want 1234", number);
        end
    endtask

    task automatic test_decode_err();
        int fv0, fe0, de0;
`ifdef SCAN_ERR_CNT_EN
        int ec0;
        ec0 = err_count;
`endif
        fv0 = fv_total; fe0 = fe_total; de0 = de_total;
        scan(16'h5678, 4, 2);
        idle(8);
        vectors++;
        if (de_total - de0 !== 1 || fe_total - fe0 !== 1 || fv_total - fv0 !== 0) begin
            miscompares++;
            $display("FAIL bad_digit_pulses: got de=%0d fe=%0d fv=%0d, want 1 1 0",
                     de_total - de0, fe_total - fe0, fv_total - fv0);
        end
        vectors++;
        if (number !== 16'h1234) begin
            miscompares++;
            $display("FAIL bad_digit_number: got %h, want 1234", number);
        end
`ifdef SCAN_ERR_CNT_EN
        vectors++;
        if (int'(err_count) - ec0 !== 1) begin
            miscompares++;
            $display("FAIL bad_digit_err_count: got +%0d, want +1", int'(err_count) - ec0);
        end
`endif
        fv0 = fv_total;
        scan(16'hBEEF, 4, -1);
        idle(8);
        vectors++;
        if (fv_total - fv0 !== 1 || number !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL beef_recover: got %h after %0d frames, want BEEF after 1", number, fv_total - fv0);
        end
    endtask

    task automatic test_multi_low();
        int fv0, fv1;
`ifdef SCAN_ERR_CNT_EN
        int ec0;
        ec0 = err_count;
`endif
        fv0 = fv_total;
        present(0, 4'h1, 4, 1'b0);
        present(1, 4'h2, 4, 1'b0);
        fv1 = fv_total;
        drive(8'b1111_0011, SEG_TAB[8], 10);
        drive(8'b1110_1111, SEG_TAB[9], 6);
        vectors++;
        if (fv_total - fv1 !== 0) begin
            miscompares++;
            $display("FAIL multi_low_ignored: got %0d frames, want 0", fv_total - fv1);
        end
        present(2, 4'h3, 4, 1'b0);
        present(3, 4'h4, 4, 1'b0);
        idle(8);
        vectors++;
        if (fv_total - fv0 !== 1 || number !== 16'h4321) begin
            miscompares++;
            $display("FAIL multi_low_frame: got %h after %0d frames, want 4321 after 1", number, fv_total - fv0);
        end
`ifdef SCAN_ERR_CNT_EN
        vectors++;
        if (int'(err_count) - ec0 !== 1) begin
            miscompares++;
            $display("FAIL multi_low_err_count: got +%0d, want +1", int'(err_count) - ec0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int fv0;
        present(0, 4'h9, 4, 1'b0);
        present(1, 4'h9, 4, 1'b0);
        pulse_reset();
        @(negedge clock);
        vectors++;
        if (number !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_number: got %h, want 0000", number);
        end
`ifdef SCAN_ERR_CNT_EN
        vectors++;
        if (err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset_err_count: got %0d, want 0", err_count);
        end
`endif
        fv0 = fv_total;
        present(2, 4'h7, 4, 1'b0);
        present(3, 4'h7, 4, 1'b0);
        idle(8);
        vectors++;
        if (fv_total - fv0 !== 0 || number !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_partial_discard: got %h after %0d frames, want 0000 after 0",
                     number, fv_total - fv0);
        end
        pulse_reset();
        fv0 = fv_total;
        scan(16'hA5C0, 4, -1);
        idle(8);
        vectors++;
        if (fv_total - fv0 !== 1 || number !== 16'hA5C0) begin
            miscompares++;
            $display("FAIL midreset_a5c0: got %h after %0d frames, want A5C0 after 1", number, fv_total - fv0);
        end
    endtask

    task automatic test_simultaneous();
        int co0, fe0;
        co0 = coinc_total; fe0 = fe_total;
        scan(16'h1111, 4, 3);
        idle(8);
        vectors++;
        if (coinc_total - co0 !== 1 || fe_total - fe0 !== 1) begin
            miscompares++;
            $display("FAIL last_digit_bad_same_cycle: got coincident=%0d fe=%0d, want 1 1",
                     coinc_total - co0, fe_total - fe0);
        end
        vectors++;
        if (number !== 16'hA5C0) begin
            miscompares++;
            $display("FAIL last_digit_bad_number: got %h, want A5C0", number);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = frames_q.size();
        for (int n = 0; n < 6; n++) scan(16'(8 * n), 4, -1);
        idle(8);
        vectors++;
        if (frames_q.size() - base !== 6) begin
            miscompares++;
            $display("FAIL loopback_frame_count: got %0d, want 6", frames_q.size() - base);
        end
        for (int n = 0; n < 6; n++) begin
            if (base + n < frames_q.size()) begin
                vectors++;
                if (frames_q[base + n] !== 16'(8 * n)) begin
                    miscompares++;
                    $display("FAIL loopback_frame%0d: got %h, want %h", n, frames_q[base + n], 16'(8 * n));
                end
            end
        end
        vectors++;
        if (both_total !== 0) begin
            miscompares++;
            $display("FAIL valid_and_err_together: got %0d cycles, want 0", both_total);
        end
    endtask

    initial begin
        test_reset();
        test_short_hold();
        test_scan_1234();
        test_decode_err();
        test_multi_low();
        test_reset_mid();
        test_simultaneous();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
